// File: rtl/sys_defs.sv
// Shared types for the ALU arbiter slice.
// DATA, ALU_FUNC, the ALU_REQ bundle and slot states.
package sys_defs;

    typedef logic [31:0] DATA;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SLTU = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9
    } ALU_FUNC;

    typedef struct packed {
        ALU_FUNC func;
        DATA     opa;
        DATA     opb;
    } ALU_REQ;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU.
// Codes above ALU_SRA give zero and flag illegal.
module alu
    import sys_defs::*;
(
    input  ALU_FUNC func,
    input  DATA     opa,
    input  DATA     opb,
    output DATA     result,
    output logic    illegal
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = opb[SHAMT_W-1:0];

    // Decode the function code into a result
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (func)
            ALU_ADD:  result = opa + opb;
            ALU_SUB:  result = opa - opb;
            ALU_SLT:  result = {31'b0, $signed(opa) < $signed(opb)};
            ALU_SLTU: result = {31'b0, opa < opb};
            ALU_AND:  result = opa & opb;
            ALU_OR:   result = opa | opb;
            ALU_XOR:  result = opa ^ opb;
            ALU_SLL:  result = opa << shamt;
            ALU_SRL:  result = opa >> shamt;
            ALU_SRA:  result = DATA'($signed(opa) >>> shamt);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU over a one-entry result slot.
// Define ALU_ARB_STATS_EN to add per-requester grant_count outputs.
module alu_arbiter
    import sys_defs::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  ALU_FUNC                    req_func [NUM_REQ],
    input  DATA                        req_opa  [NUM_REQ],
    input  DATA                        req_opb  [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output DATA                        rsp_result,
`ifdef ALU_ARB_STATS_EN
    output logic                       rsp_illegal,
    output logic [31:0]                grant_count [NUM_REQ]
`else
    output logic                       rsp_illegal
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int IW  = IDW + 1;

    slot_state_t    state_q;
    slot_state_t    state_d;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic [IW-1:0]  idx;
    logic           found;
    logic           can_accept;
    logic           xfer;
    ALU_REQ         reqs [NUM_REQ];
    ALU_REQ         sel;
    DATA            alu_result;
    logic           alu_illegal;

    // Pack the per-requester request fields into bundles
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].func = req_func[i];
            reqs[i].opa  = req_opa[i];
            reqs[i].opb  = req_opb[i];
        end
    end

    assign can_accept = !reset &&
                        (state_q == SLOT_EMPTY || rsp_ready);

    // Round-robin search starting at rr_ptr
    always_comb begin
        found     = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + IW'(k);
            if (idx >= IW'(NUM_REQ))
                idx = idx - IW'(NUM_REQ);
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found  = 1'b1;
                gnt_id = idx[IDW-1:0];
            end
        end
        if (found && can_accept)
            req_ready[gnt_id] = 1'b1;
    end

    assign xfer = found && can_accept;
    assign sel  = reqs[gnt_id];

    alu u_alu (
        .func    (sel.func),
        .opa     (sel.opa),
        .opb     (sel.opb),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    // Slot state register
    always_ff @(posedge clock) begin
        if (reset)
            state_q <= SLOT_EMPTY;
        else
            state_q <= state_d;
    end

    // Next slot state: refill wins over drain
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (xfer) state_d = SLOT_FULL;
            SLOT_FULL: begin
                if (xfer)
                    state_d = SLOT_FULL;
                else if (rsp_ready)
                    state_d = SLOT_EMPTY;
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign rsp_valid = (state_q == SLOT_FULL);

    // Capture the ALU output and advance the pointer on a transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_illegal <= 1'b0;
            rr_ptr      <= '0;
        end else if (xfer) begin
            rsp_id      <= gnt_id;
            rsp_result  <= alu_result;
            rsp_illegal <= alu_illegal;
            if (gnt_id == IDW'(NUM_REQ - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= gnt_id + 1'b1;
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating per-requester transfer counters
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset)
                grant_count[i] <= '0;
            else if (req_ready[i] && req_valid[i] &&
                     grant_count[i] != 32'hFFFF_FFFF)
                grant_count[i] <= grant_count[i] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter.
// Hand-computed vectors; inputs change on the falling edge.
module tb_alu_arbiter;
    import sys_defs::*;

    logic          clock;
    logic          reset;
    logic [3:0]    req_valid;
    ALU_FUNC       req_func [4];
    DATA           req_opa  [4];
    DATA           req_opb  [4];
    logic [3:0]    req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    DATA           rsp_result;
    logic          rsp_illegal;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]   grant_count [4];
`endif

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.NUM_REQ(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_func    (req_func),
        .req_opa     (req_opa),
        .req_opb     (req_opb),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
`ifdef ALU_ARB_STATS_EN
        .rsp_illegal (rsp_illegal),
        .grant_count (grant_count)
`else
        .rsp_illegal (rsp_illegal)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input ALU_FUNC f,
                           input DATA a, input DATA b);
        req_func[i] = f;
        req_opa[i]  = a;
        req_opb[i]  = b;
    endtask

    // Step to the rising edge, then settle past it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Step to the next falling edge to drive inputs
    task automatic fall();
        @(negedge clock);
    endtask

    ALU_FUNC    vf [8];
    DATA        va [8];
    DATA        vb [8];
    DATA        vr [8];
    logic       vi [8];

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, ALU_ADD, 0, 0);

        // Reset state
        tick();
        fall();
        #1;
        check("rst_ready", {28'b0, req_ready}, 32'h0);
        check("rst_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_id", {30'b0, rsp_id}, 32'h0);
        check("rst_result", rsp_result, 32'h0);
        check("rst_illegal", {31'b0, rsp_illegal}, 32'h0);

        // Wrap-around ADD from requester 1
        reset     = 1'b0;
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        set_req(1, ALU_ADD, 32'hFFFF_FFFF, 32'h1);
        #1;
        check("add_ready", {28'b0, req_ready}, 32'h2);
        tick();
        check("add_valid", {31'b0, rsp_valid}, 32'h1);
        check("add_id", {30'b0, rsp_id}, 32'h1);
        check("add_result", rsp_result, 32'h0);
        check("add_illegal", {31'b0, rsp_illegal}, 32'h0);
        fall();
        req_valid = 4'b0000;
        tick();
        check("drain_valid", {31'b0, rsp_valid}, 32'h0);

        // Re-reset so round-robin starts at 0
        fall();
        reset = 1'b1;
        tick();
        fall();
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            set_req(i, ALU_ADD, DATA'(i * 16), DATA'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_ready", {28'b0, req_ready},
                  32'h1 << (k % 4));
            tick();
            check("rr_id", {30'b0, rsp_id}, 32'(k % 4));
            check("rr_result", rsp_result, 32'((k % 4) * 17));
            fall();
        end
        req_valid = 4'b0000;
        tick();
        fall();

        // Backpressure: hold XOR result, requester 2 waits
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        set_req(0, ALU_XOR, 32'hA5, 32'h0F);
        tick();
        fall();
        req_valid = 4'b0100;
        set_req(2, ALU_SUB, 32'd10, 32'd3);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready", {28'b0, req_ready}, 32'h0);
            check("bp_result", rsp_result, 32'hAA);
            check("bp_id", {30'b0, rsp_id}, 32'h0);
            check("bp_valid", {31'b0, rsp_valid}, 32'h1);
            tick();
            fall();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release", {28'b0, req_ready}, 32'h4);
        tick();
        check("bp_id2", {30'b0, rsp_id}, 32'h2);
        check("bp_result2", rsp_result, 32'h7);
        fall();
        req_valid = 4'b0000;
        tick();

        // ALU function table through requester 1
        vf[0] = ALU_SLT;  va[0] = 32'h8000_0000; vb[0] = 1;
        vr[0] = 32'h1;         vi[0] = 1'b0;
        vf[1] = ALU_SLTU; va[1] = 32'h8000_0000; vb[1] = 1;
        vr[1] = 32'h0;         vi[1] = 1'b0;
        vf[2] = ALU_SRA;  va[2] = 32'h8000_0000; vb[2] = 33;
        vr[2] = 32'hC000_0000; vi[2] = 1'b0;
        vf[3] = ALU_FUNC'(4'hC); va[3] = 32'h1234; vb[3] = 5;
        vr[3] = 32'h0;         vi[3] = 1'b1;
        vf[4] = ALU_SLL;  va[4] = 32'h1;         vb[4] = 36;
        vr[4] = 32'h10;        vi[4] = 1'b0;
        vf[5] = ALU_SRL;  va[5] = 32'h8000_0000; vb[5] = 31;
        vr[5] = 32'h1;         vi[5] = 1'b0;
        vf[6] = ALU_SUB;  va[6] = 32'h0;         vb[6] = 1;
        vr[6] = 32'hFFFF_FFFF; vi[6] = 1'b0;
        vf[7] = ALU_OR;   va[7] = 32'hF0;        vb[7] = 32'h0F;
        vr[7] = 32'hFF;        vi[7] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            fall();
            req_valid = 4'b0010;
            set_req(1, vf[k], va[k], vb[k]);
            tick();
            check("alu_result", rsp_result, vr[k]);
            check("alu_illegal", {31'b0, rsp_illegal},
                  {31'b0, vi[k]});
        end

        // Reset while FULL discards the result and rr_ptr
        fall();
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_req(1, ALU_ADD, 1, 1);
        tick();
        check("pre_rst_valid", {31'b0, rsp_valid}, 32'h1);
        fall();
        req_valid = 4'b0000;
        reset     = 1'b1;
        tick();
        check("post_rst_valid", {31'b0, rsp_valid}, 32'h0);
        fall();
        reset     = 1'b0;
        req_valid = 4'b1001;
        set_req(0, ALU_ADD, 2, 2);
        set_req(3, ALU_ADD, 3, 3);
        #1;
        check("post_rst_ready", {28'b0, req_ready}, 32'h1);
        tick();
        check("post_rst_id", {30'b0, rsp_id}, 32'h0);
        check("post_rst_res", rsp_result, 32'h4);

`ifdef ALU_ARB_STATS_EN
        // Seven transfers from requester 3 only
        fall();
        reset     = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        tick();
        fall();
        reset     = 1'b0;
        req_valid = 4'b1000;
        repeat (7) begin
            tick();
            fall();
        end
        req_valid = 4'b0000;
        #1;
        check("cnt0", grant_count[0], 32'd0);
        check("cnt1", grant_count[1], 32'd0);
        check("cnt2", grant_count[2], 32'd0);
        check("cnt3", grant_count[3], 32'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
